// File: rtl/scudsp_dma_ctrl.sv
// SCU DSP DMA sequencer: moves N words between the D0 bus and a DSP data RAM bank
// or program RAM, stepping the bus address and optionally writing it back to RA0/WA0.
module scudsp_dma_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        ST,
    input  logic        DIR,
    input  logic        PRGW,
    input  logic [1:0]  RAMS,
    input  logic [2:0]  ADDI,
    input  logic        HOLD,
    input  logic [7:0]  CNT,
    input  logic [24:0] RA0,
    input  logic [24:0] WA0,
    input  logic [31:0] RAM_Q,
    output logic [3:0]  RAM_WE,
    output logic [3:0]  RAM_RE,
    output logic [3:0]  CT_INC,
    output logic [31:0] RAM_D,
    output logic        PRG_WE,
    output logic [7:0]  PRG_ADDR,
    output logic [31:0] PRG_D,
    output logic [26:0] BUS_A,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_DO,
    input  logic [31:0] BUS_DI,
    input  logic        BUS_ACK,
    output logic        RA0_WB,
    output logic        WA0_WB,
    output logic [24:0] ADDR_WB_VAL,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_RD = 3'd1;
    localparam logic [2:0] S_WR_RAM = 3'd2;
    localparam logic [2:0] S_RD_RAM = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;
    localparam logic [2:0] S_REQ_WR = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        dir_q, dir_d;
    logic        prgw_q, prgw_d;
    logic        hold_q, hold_d;
    logic [1:0]  rams_q, rams_d;
    logic [24:0] inc_q, inc_d;
    logic [24:0] addr_q, addr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  prg_addr_q, prg_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] bus_do_q, bus_do_d;

    logic [24:0] inc_sel;
    logic [3:0]  bank_oh;
    logic        to_prg;

    // PRGW only redirects writes; a RAM->D0 transfer always reads data RAM.
    assign to_prg  = prgw_q & ~dir_q;
    assign bank_oh = 4'b0001 << rams_q;
    assign inc_sel = (ADDI == 3'd0) ? 25'd0 : (25'd1 << (ADDI - 3'd1));

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        prgw_d     = prgw_q;
        hold_d     = hold_q;
        rams_d     = rams_q;
        inc_d      = inc_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        prg_addr_d = prg_addr_q;
        rd_data_d  = rd_data_q;
        bus_do_d   = bus_do_q;
        if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (ST) begin
                        dir_d      = DIR;
                        prgw_d     = PRGW;
                        hold_d     = HOLD;
                        rams_d     = RAMS;
                        inc_d      = inc_sel;
                        addr_d     = DIR ? WA0 : RA0;
                        cnt_d      = (CNT == 8'd0) ? 9'd256 : {1'b0, CNT};
                        prg_addr_d = 8'd0;
                        state_d    = DIR ? S_RD_RAM : S_REQ_RD;
                    end
                end
                S_REQ_RD: begin
                    if (BUS_ACK) begin
                        rd_data_d = BUS_DI;
                        state_d   = S_WR_RAM;
                    end
                end
                S_WR_RAM: begin
                    if (to_prg) begin
                        prg_addr_d = prg_addr_q + 8'd1;
                    end
                    addr_d  = addr_q + inc_q;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? S_FINISH : S_REQ_RD;
                end
                S_RD_RAM: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    bus_do_d = RAM_Q;
                    state_d  = S_REQ_WR;
                end
                S_REQ_WR: begin
                    if (BUS_ACK) begin
                        addr_d  = addr_q + inc_q;
                        cnt_d   = cnt_q - 9'd1;
                        state_d = (cnt_q == 9'd1) ? S_FINISH : S_RD_RAM;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            prgw_q     <= 1'b0;
            hold_q     <= 1'b0;
            rams_q     <= 2'd0;
            inc_q      <= 25'd0;
            addr_q     <= 25'd0;
            cnt_q      <= 9'd0;
            prg_addr_q <= 8'd0;
            rd_data_q  <= 32'd0;
            bus_do_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            prgw_q     <= prgw_d;
            hold_q     <= hold_d;
            rams_q     <= rams_d;
            inc_q      <= inc_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            prg_addr_q <= prg_addr_d;
            rd_data_q  <= rd_data_d;
            bus_do_q   <= bus_do_d;
        end
    end

    // Strobes are gated by CE so they last exactly one enabled cycle.
    always_comb begin
        RAM_WE      = 4'd0;
        RAM_RE      = 4'd0;
        CT_INC      = 4'd0;
        PRG_WE      = 1'b0;
        BUS_REQ     = 1'b0;
        BUS_WE      = 1'b0;
        BUS_A       = 27'd0;
        DONE        = 1'b0;
        RA0_WB      = 1'b0;
        WA0_WB      = 1'b0;
        ADDR_WB_VAL = 25'd0;
        case (state_q)
            S_REQ_RD: begin
                BUS_REQ = 1'b1;
                BUS_A   = {addr_q, 2'b00};
            end
            S_WR_RAM: begin
                if (CE) begin
                    if (to_prg) begin
                        PRG_WE = 1'b1;
                    end else begin
                        RAM_WE = bank_oh;
                        CT_INC = bank_oh;
                    end
                end
            end
            S_RD_RAM: begin
                if (CE) begin
                    RAM_RE = bank_oh;
                    CT_INC = bank_oh;
                end
            end
            S_REQ_WR: begin
                BUS_REQ = 1'b1;
                BUS_WE  = 1'b1;
                BUS_A   = {addr_q, 2'b00};
            end
            S_FINISH: begin
                if (CE) begin
                    DONE = 1'b1;
                    if (!hold_q) begin
                        RA0_WB      = ~dir_q;
                        WA0_WB      = dir_q;
                        ADDR_WB_VAL = addr_q;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign BUSY     = (state_q != S_IDLE);
    assign RAM_D    = rd_data_q;
    assign PRG_D    = rd_data_q;
    assign PRG_ADDR = prg_addr_q;
    assign BUS_DO   = bus_do_q;

endmodule

// File: tb/tb_scudsp_dma_ctrl.sv
// Self-checking bench for scudsp_dma_ctrl: table of transfers driven through a bus/RAM
// responder, with a scoreboard matching data entering the DMA against data leaving it.
module tb_scudsp_dma_ctrl;

    logic        CLK = 1'b0;
    logic        RST, CE, ST, DIR, PRGW, HOLD, BUS_ACK;
    logic [1:0]  RAMS;
    logic [2:0]  ADDI;
    logic [7:0]  CNT;
    logic [24:0] RA0, WA0;
    logic [31:0] RAM_Q, BUS_DI;
    logic [3:0]  RAM_WE, RAM_RE, CT_INC;
    logic [31:0] RAM_D, PRG_D, BUS_DO;
    logic        PRG_WE, BUS_REQ, BUS_WE, RA0_WB, WA0_WB, BUSY, DONE;
    logic [7:0]  PRG_ADDR;
    logic [26:0] BUS_A;
    logic [24:0] ADDR_WB_VAL;

    scudsp_dma_ctrl dut (
        .CLK(CLK), .RST(RST), .CE(CE), .ST(ST), .DIR(DIR), .PRGW(PRGW),
        .RAMS(RAMS), .ADDI(ADDI), .HOLD(HOLD), .CNT(CNT), .RA0(RA0), .WA0(WA0),
        .RAM_Q(RAM_Q), .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .CT_INC(CT_INC),
        .RAM_D(RAM_D), .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_D(PRG_D),
        .BUS_A(BUS_A), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_DO(BUS_DO),
        .BUS_DI(BUS_DI), .BUS_ACK(BUS_ACK), .RA0_WB(RA0_WB), .WA0_WB(WA0_WB),
        .ADDR_WB_VAL(ADDR_WB_VAL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        dir;
        logic        prgw;
        logic [1:0]  rams;
        logic [2:0]  addi;
        logic        hold;
        logic [7:0]  cnt;
        logic [24:0] base;
        int          ackWait;
        logic        ceHalf;
        logic        stAgain;
        logic        fixedData;
        int          expWords;
        logic        expWb;
        logic [24:0] expWbVal;
        int          expBusy;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  prgAddr;
    } ramExp_t;

    vec_t        vecs[7];
    ramExp_t     ramExp[$];
    logic [31:0] busExp[$];
    int          checks = 0;
    int          errors = 0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_strobes"}, {RAM_WE, RAM_RE, CT_INC, PRG_WE}, 64'd0);
        checkVal({tag, "_ctl"}, {BUS_REQ, BUS_WE, BUSY, DONE, RA0_WB, WA0_WB}, 64'd0);
        checkVal({tag, "_busA"}, BUS_A, 64'd0);
        checkVal({tag, "_busDo"}, BUS_DO, 64'd0);
        checkVal({tag, "_ramD"}, {RAM_D, PRG_D}, 64'd0);
        checkVal({tag, "_prgAddr"}, PRG_ADDR, 64'd0);
        checkVal({tag, "_wbVal"}, ADDR_WB_VAL, 64'd0);
    endtask

    // One complete transfer; the bench plays both the D0 bus slave and the DSP RAM.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] dataTab[$];
        logic [24:0] inc, modelAddr;
        logic [3:0]  oh;
        logic [31:0] ramQVal, expData;
        logic [26:0] prevA;
        logic [31:0] prevDo;
        logic        prevReq, prevWe, prevAcc, acc;
        ramExp_t     re;
        int total, words, busIdx, rdIdx, waitCnt, busyCycles, cyc;
        bit doneSeen;

        total = (v.cnt == 8'd0) ? 256 : int'(v.cnt);
        inc = (v.addi == 3'd0) ? 25'd0 : (25'd1 << (v.addi - 3'd1));
        oh = 4'b0001 << v.rams;
        for (int i = 0; i < total; i++) dataTab.push_back($urandom);
        if (v.fixedData) begin
            dataTab[0] = 32'hAAAA5555;
            dataTab[1] = 32'h12345678;
        end
        modelAddr = v.base;
        ramExp.delete();
        busExp.delete();
        words = 0; busIdx = 0; rdIdx = 0; waitCnt = 0; busyCycles = 0;
        doneSeen = 0; prevReq = 0; prevAcc = 0; prevWe = 0; prevA = '0; prevDo = '0;
        ramQVal = '0;

        @(negedge CLK);
        DIR = v.dir; PRGW = v.prgw; RAMS = v.rams; ADDI = v.addi; HOLD = v.hold; CNT = v.cnt;
        RA0 = v.dir ? 25'h0ABCDE : v.base;
        WA0 = v.dir ? v.base : 25'h1234567;
        CE = 1'b1; ST = 1'b1; BUS_ACK = 1'b0;
        #1 checkVal("busyBeforeStart", BUSY, 64'd0);
        @(negedge CLK);
        ST = 1'b0;

        cyc = 0;
        while (!doneSeen && cyc < 3000) begin
            CE = !v.ceHalf || (cyc % 2 == 0);
            ST = v.stAgain && (cyc == 3 || cyc == 4 || cyc == 9);
            if (BUS_REQ) BUS_ACK = (waitCnt >= v.ackWait);
            else BUS_ACK = (v.ackWait > 0) ? 1'($urandom_range(1)) : 1'b0;
            BUS_DI = (BUS_REQ && !BUS_WE && busIdx < total) ? dataTab[busIdx] : $urandom;
            RAM_Q = ramQVal;
            #1;
            if (BUSY) busyCycles++;
            acc = BUS_REQ && BUS_ACK && CE;
            if (prevReq && !prevAcc && BUS_REQ)
                checkVal("busHold", {BUS_A, BUS_WE, BUS_DO}, {prevA, prevWe, prevDo});
            if (!CE)
                checkVal("noStrobeWithoutCe", {RAM_WE, RAM_RE, PRG_WE, DONE}, 64'd0);
            if (acc) begin
                checkVal("busAddr", BUS_A, {modelAddr, 2'b00});
                checkVal("busWe", BUS_WE, v.dir);
                if (!v.dir) begin
                    ramExp.push_back('{data: dataTab[busIdx], prgAddr: 8'(busIdx)});
                    busIdx++;
                end else if (busExp.size() == 0) begin
                    checkVal("busWriteUnexpected", 1, 0);
                end else begin
                    expData = busExp.pop_front();
                    checkVal("busDo", BUS_DO, expData);
                end
                modelAddr = modelAddr + inc;
                words++;
            end
            if (RAM_WE != 4'd0 || PRG_WE) begin
                if (ramExp.size() == 0) begin
                    checkVal("ramWriteUnexpected", 1, 0);
                end else begin
                    re = ramExp.pop_front();
                    if (v.prgw && !v.dir) begin
                        checkVal("prgStrobes", {PRG_WE, RAM_WE, CT_INC}, {1'b1, 8'd0});
                        checkVal("prgAddr", PRG_ADDR, re.prgAddr);
                        checkVal("prgData", PRG_D, re.data);
                    end else begin
                        checkVal("ramStrobes", {PRG_WE, RAM_WE, CT_INC}, {1'b0, oh, oh});
                        checkVal("ramData", RAM_D, re.data);
                    end
                end
            end
            if (RAM_RE != 4'd0) begin
                checkVal("ramReadStrobes", {RAM_RE, CT_INC, RAM_WE}, {oh, oh, 4'd0});
                if (rdIdx < total) begin
                    ramQVal = dataTab[rdIdx];
                    busExp.push_back(dataTab[rdIdx]);
                end
                rdIdx++;
            end
            if (DONE) begin
                doneSeen = 1;
                checkVal("wordsAtDone", words, total);
                checkVal("wbFlags", {RA0_WB, WA0_WB}, {v.expWb && !v.dir, v.expWb && v.dir});
                if (v.expWb) checkVal("wbValue", ADDR_WB_VAL, v.expWbVal);
            end
            if (BUS_REQ) begin
                if (acc) waitCnt = 0;
                else if (CE) waitCnt++;
            end
            prevReq = BUS_REQ; prevAcc = acc; prevA = BUS_A; prevWe = BUS_WE; prevDo = BUS_DO;
            @(negedge CLK);
            cyc++;
        end
        ST = 1'b0; BUS_ACK = 1'b0; CE = 1'b1;
        if (!doneSeen) begin
            checkVal("doneTimeout", 0, 1);
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
        end
        #1;
        checkVal("idleAfterDone", {BUSY, DONE, RA0_WB, WA0_WB}, 64'd0);
        checkVal("wordCount", words, v.expWords);
        checkVal("scoreboardEmpty", ramExp.size() + busExp.size(), 0);
        if (v.expBusy > 0) checkVal("busyCycles", busyCycles, v.expBusy);
    endtask

    initial begin
        // dir prgw rams addi hold cnt base ackWait ceHalf stAgain fixed words wb wbVal busy
        vecs[0] = '{1'b0, 1'b0, 2'd1, 3'd1, 1'b0, 8'd3, 25'h0000100, 0, 1'b0, 1'b0, 1'b0, 3,   1'b1, 25'h0000103, 7};
        vecs[1] = '{1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'd0, 25'h0000055, 0, 1'b0, 1'b0, 1'b0, 256, 1'b0, 25'h0, 513};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 3'd2, 1'b0, 8'd2, 25'h0000020, 0, 1'b0, 1'b0, 1'b1, 2,   1'b1, 25'h0000024, 7};
        vecs[3] = '{1'b0, 1'b1, 2'd0, 3'd7, 1'b0, 8'd4, 25'h1FFFFC0, 0, 1'b0, 1'b0, 1'b0, 4,   1'b1, 25'h00000C0, 9};
        vecs[4] = '{1'b0, 1'b0, 2'd3, 3'd3, 1'b0, 8'd3, 25'h0001000, 5, 1'b1, 1'b1, 1'b0, 3,   1'b1, 25'h000100C, 0};
        vecs[5] = '{1'b1, 1'b0, 2'd0, 3'd1, 1'b0, 8'd2, 25'h1FFFFFF, 5, 1'b1, 1'b1, 1'b0, 2,   1'b1, 25'h0000001, 0};
        vecs[6] = '{1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 8'd3, 25'h0000040, 0, 1'b0, 1'b0, 1'b0, 3,   1'b1, 25'h0000058, 10};

        RST = 1'b1; CE = 1'b1; ST = 1'b0; DIR = 1'b0; PRGW = 1'b0; RAMS = 2'd0; ADDI = 3'd0;
        HOLD = 1'b0; CNT = 8'd0; RA0 = '0; WA0 = '0; RAM_Q = '0; BUS_DI = '0; BUS_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1 checkAllZero("reset");

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        // Reset during the second word of a 4-word D0->RAM transfer.
        @(negedge CLK);
        DIR = 1'b0; PRGW = 1'b0; RAMS = 2'd1; ADDI = 3'd1; HOLD = 1'b0; CNT = 8'd4;
        RA0 = 25'h0000300; CE = 1'b1; ST = 1'b1; BUS_ACK = 1'b0;
        @(negedge CLK);
        ST = 1'b0; BUS_ACK = 1'b1;
        @(negedge CLK);
        BUS_ACK = 1'b0;
        @(negedge CLK);
        BUS_ACK = 1'b1;
        #1 checkVal("rstSecondWordReq", {BUS_REQ, BUS_A}, {1'b1, 25'h0000301, 2'b00});
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; BUS_ACK = 1'b0;
        #1 checkAllZero("midReset");
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1 checkVal("noDoneAfterReset", {DONE, RA0_WB, WA0_WB, BUS_REQ}, 64'd0);
        end
        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
